// File: rtl/result_buf_pkg.sv
// rtl/result_buf_pkg.sv - shared constants and entry record for the result buffer (RESULT_BUF_PARITY_EN adds parity)
package result_buf_pkg;

   localparam int DEPTH  = 2;
   localparam int CNT_W  = 2;
   localparam int DATA_W = 16;

   // One stored word plus the flags captured when it was written
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              zr;
      logic              ng;
`ifdef RESULT_BUF_PARITY_EN
      logic              par;
`endif
   } entry_t;

endpackage

// File: rtl/result_flags.sv
// rtl/result_flags.sv - combinational zero/negative/parity flags of a word (par only with RESULT_BUF_PARITY_EN)
module result_flags #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] word,
   output logic             zr,
`ifdef RESULT_BUF_PARITY_EN
   output logic             par,
`endif
   output logic             ng
);

   // Flags are pure functions of the word being written
   always_comb begin
      zr = (word == '0);
      ng = word[WIDTH-1];
`ifdef RESULT_BUF_PARITY_EN
      par = ^word;
`endif
   end

endmodule

// File: rtl/result_buf16.sv
// rtl/result_buf16.sv - two-entry result FIFO with stored zr/ng flags (RESULT_BUF_PARITY_EN adds out_par)
module result_buf16
   import result_buf_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zr,
   output logic             out_ng,
`ifdef RESULT_BUF_PARITY_EN
   output logic             out_par,
`endif
   output logic [1:0]       count
);

   logic [CNT_W-1:0] count_q;
   logic             wr_ptr;
   logic             rd_ptr;
   entry_t           mem [DEPTH];
   entry_t           new_entry;
   entry_t           head;
   logic             push;
   logic             pop;
   logic             flag_zr;
   logic             flag_ng;
`ifdef RESULT_BUF_PARITY_EN
   logic             flag_par;
`endif

   result_flags #(.WIDTH(WIDTH)) u_flags (
      .word (in_data),
      .zr   (flag_zr),
`ifdef RESULT_BUF_PARITY_EN
      .par  (flag_par),
`endif
      .ng   (flag_ng)
   );

   // Handshakes; a pop frees a slot in the same cycle so a full buffer can still accept
   always_comb begin
      pop      = (count_q != '0) && out_ready;
      in_ready = (count_q < CNT_W'(DEPTH)) || pop;
      push     = in_valid && in_ready;
   end

   // Assemble the entry with its flags so they never need recomputing at the output
   always_comb begin
      new_entry      = '0;
      new_entry.data = DATA_W'(in_data);
      new_entry.zr   = flag_zr;
      new_entry.ng   = flag_ng;
`ifdef RESULT_BUF_PARITY_EN
      new_entry.par  = flag_par;
`endif
   end

   // Storage, pointers and occupancy; when full, push and pop share the head slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head outputs come straight from flops, so reset clears them with the storage
   always_comb begin
      head      = mem[rd_ptr];
      out_valid = (count_q != '0);
      out_data  = WIDTH'(head.data);
      out_zr    = head.zr;
      out_ng    = head.ng;
`ifdef RESULT_BUF_PARITY_EN
      out_par   = head.par;
`endif
      count     = count_q;
   end

endmodule
